// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths, ALU function codes, instruction field
// positions and issue-FSM state encoding for the alu_issue block.
// Ports: none (package).
package cpu_pkg;
    localparam int DW   = 12;
    localparam int NREG = 4;

    typedef enum logic [2:0] {
        F_ADD  = 3'd0,
        F_SUB  = 3'd1,
        F_AND  = 3'd2,
        F_OR   = 3'd3,
        F_XOR  = 3'd4,
        F_ROTL = 3'd5,
        F_ROTR = 3'd6,
        F_MOV  = 3'd7
    } func_t;

    localparam int FUNC_HI     = 15;
    localparam int FUNC_LO     = 13;
    localparam int RD_HI       = 12;
    localparam int RD_LO       = 11;
    localparam int RB_HI       = 10;
    localparam int RB_LO       = 9;
    localparam int CEN_BIT     = 8;
    localparam int IMM_SEL_BIT = 7;
    localparam int IMM_HI      = 6;
    localparam int IMM_LO      = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;
endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: bundle of the alu_issue instruction, register-load and result
// handshakes plus the registered flags.
// Modports: master (instruction source / result sink), slave (alu_issue).
interface alu_issue_if;
    import cpu_pkg::*;
    logic          instr_valid;
    logic [15:0]   instr_data;
    logic          instr_ready;
    logic          wr_en;
    logic [1:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic          flag_carry;
    logic          flag_equ;
    logic          flag_ovf;

    modport master (
        output instr_valid, instr_data, wr_en, wr_addr, wr_data, res_ready,
        input  instr_ready, res_valid, res_data, flag_carry, flag_equ, flag_ovf
    );
    modport slave (
        input  instr_valid, instr_data, wr_en, wr_addr, wr_data, res_ready,
        output instr_ready, res_valid, res_data, flag_carry, flag_equ, flag_ovf
    );
endinterface

// File: rtl/alu_issue_alu.sv
// alu: combinational 12-bit ALU used by alu_issue.
// Ports: func (operation), a/b (operands), cin (carry/borrow in),
//        y (result), carry/ovf (only ADD/SUB, else 0), equ (a == b).
module alu
    import cpu_pkg::*;
(
    input  func_t         func,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          cin,
    output logic [DW-1:0] y,
    output logic          carry,
    output logic          equ,
    output logic          ovf
);
    logic [DW:0] sum;
    logic [DW:0] dif;
    logic [3:0]  s;

    always_comb begin
        sum = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
        // carry out of SUB is the borrow; cin acts as borrow-in
        dif = {1'b0, a} - {1'b0, b} - {{DW{1'b0}}, cin};
        // rotate amount is b[3:0] reduced modulo the 12-bit width
        s = (b[3:0] >= 4'd12) ? b[3:0] - 4'd12 : b[3:0];
        case (func)
            F_ADD:   y = sum[DW-1:0];
            F_SUB:   y = dif[DW-1:0];
            F_AND:   y = a & b;
            F_OR:    y = a | b;
            F_XOR:   y = a ^ b;
            F_ROTL:  y = (a << s) | (a >> (4'd12 - s));
            F_ROTR:  y = (a >> s) | (a << (4'd12 - s));
            default: y = b;
        endcase
        carry = (func == F_ADD) ? sum[DW] : (func == F_SUB) ? dif[DW] : 1'b0;
        ovf   = (func == F_ADD) ? (a[DW-1] == b[DW-1]) && (y[DW-1] != a[DW-1]) :
                (func == F_SUB) ? (a[DW-1] != b[DW-1]) && (y[DW-1] != a[DW-1]) : 1'b0;
        equ   = a == b;
    end
endmodule

// File: rtl/alu_issue.sv
// alu_issue: single-issue wrapper around alu with a 4x12 register file,
// IDLE -> EXEC -> RESP handshake FSM and registered flags.
// Ports: clk, rst_n (async active-low), bus (alu_issue_if.slave: instruction
//        offer/accept, external register load, result handshake, flags).
// Optional feature: define ALU_ISSUE_IMM_EN to let instr bit 7 select the
//        zero-extended imm7 as operand B.
module alu_issue
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    alu_issue_if.slave bus
);
    state_t        state, state_nx;
    logic [DW-1:0] regs [NREG];
    func_t         func_q;
    logic [1:0]    rd_q;
    logic [DW-1:0] a_q, b_q;
    logic          cin_q;
    logic [DW-1:0] b_sel;
    logic [DW-1:0] y;
    logic          carry, equ, ovf;
    logic          accept;
    logic [15:0]   instr;
    logic [1:0]    rd, rb;

    assign instr  = bus.instr_data;
    assign rd     = instr[RD_HI:RD_LO];
    assign rb     = instr[RB_HI:RB_LO];
    assign accept = bus.instr_ready && bus.instr_valid;

`ifdef ALU_ISSUE_IMM_EN
    assign b_sel = instr[IMM_SEL_BIT] ? {{(DW-7){1'b0}}, instr[IMM_HI:IMM_LO]} : regs[rb];
`else
    logic unused_imm;
    assign unused_imm = ^instr[IMM_SEL_BIT:IMM_LO];
    assign b_sel = regs[rb];
`endif

    alu u_alu (
        .func  (func_q),
        .a     (a_q),
        .b     (b_sel_q()),
        .cin   (cin_q),
        .y     (y),
        .carry (carry),
        .equ   (equ),
        .ovf   (ovf)
    );

    function automatic logic [DW-1:0] b_sel_q();
        return b_q;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx        = state;
        bus.instr_ready = 1'b0;
        bus.res_valid   = 1'b0;
        case (state)
            S_IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) state_nx = S_EXEC;
            end
            S_EXEC: state_nx = S_RESP;
            S_RESP: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // operands are captured at accept so later register loads cannot disturb them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func_q <= F_ADD;
            rd_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cin_q  <= 1'b0;
        end else if (accept) begin
            func_q <= func_t'(instr[FUNC_HI:FUNC_LO]);
            rd_q   <= rd;
            a_q    <= regs[rd];
            b_q    <= b_sel;
            cin_q  <= bus.flag_carry & instr[CEN_BIT];
        end
    end

    // EXEC writeback takes priority over an external load to the same register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++)
                if (state == S_EXEC && rd_q == 2'(i)) regs[i] <= y;
                else if (bus.wr_en && bus.wr_addr == 2'(i)) regs[i] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.res_data   <= '0;
            bus.flag_carry <= 1'b0;
            bus.flag_equ   <= 1'b0;
            bus.flag_ovf   <= 1'b0;
        end else if (state == S_EXEC) begin
            bus.res_data   <= y;
            bus.flag_carry <= carry;
            bus.flag_equ   <= equ;
            bus.flag_ovf   <= ovf;
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed-vector bench for alu_issue with a result scoreboard.
// Expected {res_data, carry, equ, ovf} are pushed at issue time and popped by
// a monitor whenever a result handshake is seen.
module tb_alu_issue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_if bus();
    alu_issue dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
    localparam logic [2:0] XOR_ = 3'd4, ROTL = 3'd5, ROTR = 3'd6, MOV = 3'd7;

    int checks = 0;
    int errors = 0;
    logic [14:0] exp_q [$];
    logic [14:0] exp_v;
    int n_res = 0;

    function automatic logic [15:0] mk(logic [2:0] f, logic [1:0] rd, logic [1:0] rb,
                                       logic c, logic i, logic [6:0] imm);
        return {f, rd, rb, c, i, imm};
    endfunction

    function automatic logic [14:0] ex(logic [11:0] d, logic c, logic e, logic o);
        return {d, c, e, o};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.res_valid && bus.res_ready) begin
            n_res++;
            if (exp_q.size() == 0) check($sformatf("result%0d_unexpected", n_res), 32'd1, 32'd0);
            else begin
                exp_v = exp_q.pop_front();
                check($sformatf("result%0d", n_res),
                      {17'd0, bus.res_data, bus.flag_carry, bus.flag_equ, bus.flag_ovf}, {17'd0, exp_v});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.instr_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.instr_ready) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr(logic [1:0] a, logic [11:0] d);
        wait_idle();
        bus.wr_en = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic issue(logic [15:0] ins, logic [14:0] e, bit push);
        wait_idle();
        bus.instr_valid = 1'b1;
        bus.instr_data = ins;
        if (push) exp_q.push_back(e);
        tick();
        bus.instr_valid = 1'b0;
        bus.instr_data = 16'($urandom);
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr_data = '0;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("rst_instr_ready", bus.instr_ready, 1);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_flags", {bus.flag_carry, bus.flag_equ, bus.flag_ovf}, 0);

        wr(0, 12'hFFF); wr(1, 12'h001);
        issue(mk(ADD, 0, 1, 0, 0, 0), ex(12'h000, 1, 0, 0), 1);
        wr(2, 12'h000); wr(3, 12'h000);
        issue(mk(ADD, 2, 3, 1, 0, 0), ex(12'h001, 0, 1, 0), 1);
        issue(mk(OR_, 0, 0, 0, 0, 0), ex(12'h000, 0, 1, 0), 1);
        wr(0, 12'h800); wr(1, 12'h001);
        issue(mk(SUB, 0, 1, 0, 0, 0), ex(12'h7FF, 0, 0, 1), 1);
        wr(2, 12'h801); wr(3, 12'h001);
        issue(mk(ROTL, 2, 3, 0, 0, 0), ex(12'h003, 0, 0, 0), 1);
        issue(mk(AND_, 2, 1, 0, 0, 0), ex(12'h001, 0, 0, 0), 1);
        issue(mk(XOR_, 2, 1, 0, 0, 0), ex(12'h000, 0, 1, 0), 1);
        wr(3, 12'h003); wr(0, 12'h002);
        issue(mk(ROTR, 3, 0, 0, 0, 0), ex(12'hC00, 0, 0, 0), 1);
        issue(mk(MOV, 1, 3, 0, 0, 0), ex(12'hC00, 0, 0, 0), 1);
        wr(2, 12'h00D);
        issue(mk(ROTL, 3, 2, 0, 0, 0), ex(12'h801, 0, 0, 0), 1);
        wr(0, 12'h7FF); wr(1, 12'h001);
        issue(mk(ADD, 0, 1, 0, 0, 0), ex(12'h800, 0, 0, 1), 1);
        wr(2, 12'h000); wr(3, 12'h001);
        issue(mk(SUB, 2, 3, 0, 0, 0), ex(12'hFFF, 1, 0, 0), 1);
        issue(mk(SUB, 3, 3, 1, 0, 0), ex(12'hFFF, 1, 1, 0), 1);

        // result held while the sink stalls
        wr(1, 12'h001);
        bus.res_ready = 1'b0;
        issue(mk(OR_, 1, 1, 0, 0, 0), ex(12'h001, 0, 1, 0), 1);
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            check("stall_res_valid", bus.res_valid, 1);
            check("stall_res_data", bus.res_data, 12'h001);
            check("stall_instr_ready", bus.instr_ready, 0);
        end
        tick();
        bus.res_ready = 1'b1;

        // external load during EXEC loses to writeback of the same register
        wr(0, 12'h123);
        wait_idle();
        bus.instr_valid = 1'b1;
        bus.instr_data = mk(ADD, 0, 0, 0, 0, 0);
        exp_q.push_back(ex(12'h246, 0, 1, 0));
        tick();
        bus.instr_valid = 1'b0;
        bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 12'h555;
        tick();
        bus.wr_en = 1'b0;
        issue(mk(OR_, 0, 0, 0, 0, 0), ex(12'h246, 0, 1, 0), 1);

        // reset during EXEC drops the in-flight instruction
        issue(mk(ADD, 1, 1, 0, 0, 0), '0, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_res_valid", bus.res_valid, 0);
        check("mid_rst_res_data", bus.res_data, 0);
        check("mid_rst_flags", {bus.flag_carry, bus.flag_equ, bus.flag_ovf}, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("post_rst_instr_ready", bus.instr_ready, 1);
        for (int r = 0; r < 4; r++)
            issue(mk(OR_, 2'(r), 2'(r), 0, 0, 0), ex(12'h000, 0, 1, 0), 1);

        wr(0, 12'h010); wr(1, 12'h005);
`ifdef ALU_ISSUE_IMM_EN
        issue(mk(ADD, 0, 1, 0, 1, 7'h7F), ex(12'h08F, 0, 0, 0), 1);
`else
        issue(mk(ADD, 0, 1, 0, 1, 7'h7F), ex(12'h015, 0, 0, 0), 1);
`endif

        for (int n = 0; n < 50 && exp_q.size() != 0; n++) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
